// File: rtl/flappy_pkg.sv
// Shared Flappy Bird constants: FSM encoding, sprite/pipe geometry and score width.
package flappy_pkg;

    // Game FSM encoding, also exported on the State debug port.
    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_PLAY  = 2'b01;
    localparam logic [STATE_W-1:0] ST_DYING = 2'b10;
    localparam logic [STATE_W-1:0] ST_OVER  = 2'b11;

    // Screen geometry shared with pipe, FlappyBird and vga_bitchange.
    localparam int COORD_W = 10;
    localparam int BIRD_W  = 20;
    localparam int BIRD_H  = 20;
    localparam int PIPE_W  = 50;
    localparam int GAP_H   = 120;
    localparam int FLOOR_Y = 470;

    // Four BCD digits.
    localparam int SCORE_W = 16;

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so coordinate + size sums never wrap.
    typedef logic [COORD_W:0]   coordWide_t;
    typedef logic [SCORE_W-1:0] bcdScore_t;

endpackage

// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the board/datapath side and the game controller.
//
// Signalling: there is no valid/ready handshake here. Start and Flap_Button
// are raw asynchronous levels; the controller synchronises them itself.
// Frame_Tick, Restart and Flap_Pulse are single-cycle strobes in the Clk
// domain that consumers act on in the cycle they are high; Run, Lost, Score,
// HiScore and State are registered levels.
interface flappy_game_ctrl_if;
    import flappy_pkg::*;

    logic                 Start;
    logic                 Flap_Button;
    coord_t               BirdX;
    coord_t               BirdY;
    coord_t               PipeX1;
    coord_t               PipeY1;
    coord_t               PipeX2;
    coord_t               PipeY2;

    logic                 Frame_Tick;
    logic                 Run;
    logic                 Restart;
    logic                 Flap_Pulse;
    logic                 Lost;
    bcdScore_t            Score;
    bcdScore_t            HiScore;
    logic [STATE_W-1:0]   State;

    // Board / datapath side.
    modport master (
        output Start, Flap_Button, BirdX, BirdY, PipeX1, PipeY1, PipeX2, PipeY2,
        input  Frame_Tick, Run, Restart, Flap_Pulse, Lost, Score, HiScore, State
    );

    // Game controller side.
    modport slave (
        input  Start, Flap_Button, BirdX, BirdY, PipeX1, PipeY1, PipeX2, PipeY2,
        output Frame_Tick, Run, Restart, Flap_Pulse, Lost, Score, HiScore, State
    );

endinterface

// File: rtl/flappy_game_ctrl_bcd_counter4.sv
// Four-digit BCD counter with synchronous clear, +1/+2 steps, saturating at 9999.
module bcd_counter4
    import flappy_pkg::*;
(
    input  logic      clk,
    input  logic      rstN,
    input  logic      clear,
    input  logic      inc1,
    input  logic      inc2,
    output bcdScore_t count
);

    bcdScore_t  countNext;
    logic [4:0] digitSum;
    logic [4:0] carry;

    // Ripple the step through the digits; a carry out of the thousands digit
    // means the value passed 9999, so pin it there.
    always_comb begin
        countNext = count;
        digitSum  = '0;
        carry     = inc2 ? 5'd2 : (inc1 ? 5'd1 : 5'd0);
        for (int i = 0; i < 4; i++) begin
            digitSum = {1'b0, count[4*i +: 4]} + carry;
            if (digitSum > 5'd9) begin
                countNext[4*i +: 4] = 4'(digitSum - 5'd10);
                carry               = 5'd1;
            end else begin
                countNext[4*i +: 4] = digitSum[3:0];
                carry               = 5'd0;
            end
        end
        if (carry != 5'd0) countNext = 16'h9999;
    end

    // Clear has priority over counting.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)      count <= '0;
        else if (clear) count <= '0;
        else            count <= countNext;
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: frame tick, button conditioning, game FSM,
// collision detection and BCD score / high score.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int FRAME_DIV   = 1666667,
    parameter int DEATH_TICKS = 60
) (
    input  logic              Clk,
    input  logic              Reset,
    flappy_game_ctrl_if.slave bus
);

    localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int DW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS + 1) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
    localparam logic [DW-1:0] DEATH_LOAD = DW'(DEATH_TICKS);

    logic [2:0]         startSync, flapSync;
    logic               startEdge, flapEdge;
    logic [FW-1:0]      frameCnt;
    logic               frameTick;
    logic [STATE_W-1:0] state, stateNext;
    logic [DW-1:0]      deathCnt, deathNext;
    logic [1:0]         passFlag;
    logic               passed1, passed2, newPass1, newPass2;
    logic               hit;
    logic               scoreTick, scoreClear, scoreInc1, scoreInc2;
    logic               runQ, restartQ, flapQ, lostQ;
    bcdScore_t          score, hiScore;

    // Bird overlaps pipe horizontally and is not inside the gap.
    function automatic logic pipeHit(input coord_t bx, by, px, py);
        coordWide_t birdRight, birdBottom, pipeRight, gapBottom;
        birdRight  = {1'b0, bx} + coordWide_t'(BIRD_W);
        birdBottom = {1'b0, by} + coordWide_t'(BIRD_H);
        pipeRight  = {1'b0, px} + coordWide_t'(PIPE_W);
        gapBottom  = {1'b0, py} + coordWide_t'(GAP_H);
        return (birdRight > {1'b0, px}) && ({1'b0, bx} < pipeRight) &&
               (({1'b0, by} < {1'b0, py}) || (birdBottom > gapBottom));
    endfunction

    // Pipe's right edge is at or left of the bird's left edge.
    function automatic logic pipePassed(input coord_t bx, px);
        return ({1'b0, px} + coordWide_t'(PIPE_W)) <= {1'b0, bx};
    endfunction

    // Two-flop synchroniser plus a third flop for rising-edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            startSync <= '0;
            flapSync  <= '0;
        end else begin
            startSync <= {startSync[1:0], bus.Start};
            flapSync  <= {flapSync[1:0], bus.Flap_Button};
        end
    end

    assign startEdge = startSync[1] & ~startSync[2];
    assign flapEdge  = flapSync[1] & ~flapSync[2];

    // Free-running frame divider, active in every state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                   frameCnt <= '0;
        else if (frameCnt == FRAME_LAST) frameCnt <= '0;
        else                          frameCnt <= frameCnt + FW'(1);
    end

    assign frameTick = (frameCnt == FRAME_LAST);

    assign hit = pipeHit(bus.BirdX, bus.BirdY, bus.PipeX1, bus.PipeY1) ||
                 pipeHit(bus.BirdX, bus.BirdY, bus.PipeX2, bus.PipeY2) ||
                 (({1'b0, bus.BirdY} + coordWide_t'(BIRD_H)) > coordWide_t'(FLOOR_Y));

    assign passed1    = pipePassed(bus.BirdX, bus.PipeX1);
    assign passed2    = pipePassed(bus.BirdX, bus.PipeX2);
    assign scoreTick  = frameTick && (state == ST_PLAY);
    assign newPass1   = passed1 && !passFlag[0];
    assign newPass2   = passed2 && !passFlag[1];
    assign scoreClear = (state == ST_IDLE) && startEdge;
    assign scoreInc1  = scoreTick && (newPass1 ^ newPass2);
    assign scoreInc2  = scoreTick && newPass1 && newPass2;

    // Pass flags track "already scored" per pipe; they drop once the pipe respawns.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)          passFlag <= '0;
        else if (scoreClear) passFlag <= '0;
        else if (scoreTick)  passFlag <= {passed2, passed1};
    end

    bcd_counter4 uScore (
        .clk   (Clk),
        .rstN  (Reset),
        .clear (scoreClear),
        .inc1  (scoreInc1),
        .inc2  (scoreInc2),
        .count (score)
    );

    // Game FSM next-state and death countdown.
    always_comb begin
        stateNext = state;
        deathNext = deathCnt;
        case (state)
            ST_IDLE:  if (startEdge) stateNext = ST_PLAY;
            ST_PLAY:  if (frameTick && hit) begin
                          stateNext = ST_DYING;
                          deathNext = DEATH_LOAD;
                      end
            ST_DYING: if (frameTick) begin
                          if (deathCnt <= DW'(1)) begin
                              stateNext = ST_OVER;
                              deathNext = '0;
                          end else begin
                              deathNext = deathCnt - DW'(1);
                          end
                      end
            ST_OVER:  if (startEdge) stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // State, registered control outputs and high score capture on entry to OVER.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            deathCnt <= '0;
            runQ     <= 1'b0;
            restartQ <= 1'b0;
            flapQ    <= 1'b0;
            lostQ    <= 1'b0;
            hiScore  <= '0;
        end else begin
            state    <= stateNext;
            deathCnt <= deathNext;
            runQ     <= (stateNext == ST_PLAY);
            restartQ <= scoreClear;
            flapQ    <= (state == ST_PLAY) && flapEdge;
            lostQ    <= (stateNext == ST_OVER);
            if ((state == ST_DYING) && (stateNext == ST_OVER) && (score > hiScore))
                hiScore <= score;
        end
    end

    assign bus.Frame_Tick = frameTick;
    assign bus.Run        = runQ;
    assign bus.Restart    = restartQ;
    assign bus.Flap_Pulse = flapQ;
    assign bus.Lost       = lostQ;
    assign bus.Score      = score;
    assign bus.HiScore    = hiScore;
    assign bus.State      = state;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl with a frame-level reference model.
module tb_flappy_game_ctrl;

    localparam int FRAME_DIV   = 4;
    localparam int DEATH_TICKS = 3;
    localparam int BIRD_W  = 20;
    localparam int BIRD_H  = 20;
    localparam int PIPE_W  = 50;
    localparam int GAP_H   = 120;
    localparam int FLOOR_Y = 470;
    localparam logic [1:0] S_IDLE = 2'b00, S_PLAY = 2'b01, S_DYING = 2'b10, S_OVER = 2'b11;

    typedef struct packed {
        logic        restart;
        logic        flap;
        logic [1:0]  state;
        logic        run;
        logic        lost;
        logic [15:0] score;
        logic [15:0] hi;
    } exp_t;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    flappy_game_ctrl_if bus();

    flappy_game_ctrl #(.FRAME_DIV(FRAME_DIV), .DEATH_TICKS(DEATH_TICKS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic        sat_clear = 1'b0;
    logic        sat_inc1  = 1'b0;
    logic        sat_inc2  = 1'b0;
    logic [15:0] sat_count;

    bcd_counter4 sat (
        .clk   (Clk),
        .rstN  (Reset),
        .clear (sat_clear),
        .inc1  (sat_inc1),
        .inc2  (sat_inc2),
        .count (sat_count)
    );

    always #5 Clk = ~Clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    bit   mon_en   = 1'b0;

    // Reference model state (integers, frame granularity).
    logic [1:0] m_state;
    int m_score, m_hi, m_death, m_flaps, m_restarts;
    bit m_flag[2];
    int restart_seen = 0;
    int flap_seen    = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_score = 0;
        m_hi    = 0;
        m_death = 0;
        m_flag[0] = 1'b0;
        m_flag[1] = 1'b0;
    endtask

    // One frame: apply inputs/buttons at frame start, predict, wait for the tick.
    task automatic step(input int bx, input int by, input int px1, input int py1,
                        input int px2, input int py2, input bit st, input bit fl);
        exp_t e;
        int px[2];
        int py[2];
        int inc;
        bit hit;
        int n;
        px[0] = px1; px[1] = px2; py[0] = py1; py[1] = py2;
        bus.BirdX  = 10'(bx);
        bus.BirdY  = 10'(by);
        bus.PipeX1 = 10'(px1);
        bus.PipeY1 = 10'(py1);
        bus.PipeX2 = 10'(px2);
        bus.PipeY2 = 10'(py2);
        bus.Start       = st;
        bus.Flap_Button = fl;
        e = '0;
        if (fl && m_state == S_PLAY) begin
            e.flap = 1'b1;
            m_flaps++;
        end
        if (st && m_state == S_IDLE) begin
            m_state = S_PLAY;
            m_score = 0;
            m_flag[0] = 1'b0;
            m_flag[1] = 1'b0;
            e.restart = 1'b1;
            m_restarts++;
        end else if (st && m_state == S_OVER) begin
            m_state = S_IDLE;
        end
        if (m_state == S_PLAY) begin
            inc = 0;
            hit = (by + BIRD_H > FLOOR_Y);
            for (int k = 0; k < 2; k++) begin
                if (px[k] + PIPE_W <= bx) begin
                    if (!m_flag[k]) inc++;
                    m_flag[k] = 1'b1;
                end else begin
                    m_flag[k] = 1'b0;
                end
                if (bx + BIRD_W > px[k] && bx < px[k] + PIPE_W &&
                    (by < py[k] || by + BIRD_H > py[k] + GAP_H)) hit = 1'b1;
            end
            m_score = (m_score + inc > 9999) ? 9999 : m_score + inc;
            if (hit) begin
                m_state = S_DYING;
                m_death = DEATH_TICKS;
            end
        end else if (m_state == S_DYING) begin
            m_death--;
            if (m_death <= 0) begin
                m_state = S_OVER;
                if (m_score > m_hi) m_hi = m_score;
            end
        end
        e.state = m_state;
        e.run   = (m_state == S_PLAY);
        e.lost  = (m_state == S_OVER);
        e.score = to_bcd(m_score);
        e.hi    = to_bcd(m_hi);
        exp_q.push_back(e);
        @(negedge Clk);
        @(negedge Clk);
        bus.Start       = 1'b0;
        bus.Flap_Button = 1'b0;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!bus.Frame_Tick && n < 16);
        if (!bus.Frame_Tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no Frame_Tick within %0d cycles", n);
        end
        @(negedge Clk);
    endtask

    // Monitor: strobes sampled in the tick cycle, levels one cycle later.
    initial begin
        exp_t e;
        logic r, f;
        forever begin
            @(negedge Clk);
            if (mon_en && Reset && bus.Frame_Tick) begin
                r = bus.Restart;
                f = bus.Flap_Pulse;
                @(negedge Clk);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tick: got tick, expected none queued");
                end else begin
                    e = exp_q.pop_front();
                    check("restart", r, e.restart);
                    check("flap_pulse", f, e.flap);
                    check("state", bus.State, e.state);
                    check("run", bus.Run, e.run);
                    check("lost", bus.Lost, e.lost);
                    check("score", bus.Score, e.score);
                    check("hiscore", bus.HiScore, e.hi);
                end
            end
        end
    end

    // Pulse counters catch strobes that are too long or appear off-tick.
    always @(negedge Clk) begin
        if (Reset) begin
            if (bus.Restart)    restart_seen++;
            if (bus.Flap_Pulse) flap_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int a;
        int extra;
        int r;
        bus.Start = 1'b0; bus.Flap_Button = 1'b0;
        bus.BirdX = 10'd100; bus.BirdY = 10'd200;
        bus.PipeX1 = 10'd600; bus.PipeY1 = 10'd150;
        bus.PipeX2 = 10'd700; bus.PipeY2 = 10'd150;
        model_reset();
        m_flaps = 0; m_restarts = 0;

        // Reset state.
        #3 Reset = 1'b0;
        #4;
        check("rst_state", bus.State, S_IDLE);
        check("rst_run", bus.Run, 0);
        check("rst_restart", bus.Restart, 0);
        check("rst_flap", bus.Flap_Pulse, 0);
        check("rst_tick", bus.Frame_Tick, 0);
        check("rst_lost", bus.Lost, 0);
        check("rst_score", bus.Score, 0);
        check("rst_hiscore", bus.HiScore, 0);
        repeat (2) @(negedge Clk);
        Reset  = 1'b1;
        mon_en = 1'b1;

        // Start and first pass.
        step(100, 200, 600, 150, 700, 150, 1, 0);
        step(100, 200, 60, 150, 700, 150, 0, 0);
        step(100, 200, 55, 150, 700, 150, 0, 0);
        step(100, 200, 50, 150, 700, 150, 0, 0);
        step(100, 200, 45, 150, 700, 150, 0, 0);
        step(100, 200, 40, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 50, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 1);
        // Pipe hit, flaps dropped in DYING and OVER.
        step(100, 200, 90, 250, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 1);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 1);
        step(100, 200, 600, 150, 700, 150, 1, 0);
        step(100, 200, 600, 150, 700, 150, 1, 0);
        // Floor hit.
        step(100, 460, 600, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 1);
        step(100, 200, 600, 150, 700, 150, 1, 0);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 1, 0);
        step(100, 200, 600, 150, 700, 150, 1, 0);
        // Double passes, single pass, then pass + collision on one tick.
        step(100, 200, 50, 150, 40, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 50, 150, 40, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 50, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 50, 150, 40, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 50, 150, 90, 250, 0, 0);
        repeat (3) step(100, 200, 600, 150, 700, 150, 0, 0);
        step(100, 200, 600, 150, 700, 150, 1, 0);
        step(100, 200, 600, 150, 700, 150, 1, 0);
        step(100, 200, 50, 150, 700, 150, 0, 0);

        // Asynchronous reset mid-PLAY, away from any clock edge.
        #2;
        check("queue_pre_reset", exp_q.size(), 0);
        Reset = 1'b0;
        #1;
        check("async_state", bus.State, S_IDLE);
        check("async_run", bus.Run, 0);
        check("async_lost", bus.Lost, 0);
        check("async_score", bus.Score, 0);
        check("async_hiscore", bus.HiScore, 0);
        check("async_tick", bus.Frame_Tick, 0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;

        // Randomised play.
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            step($urandom_range(40, 300), $urandom_range(0, 470),
                 $urandom_range(0, 700), $urandom_range(0, 350),
                 $urandom_range(0, 700), $urandom_range(0, 350),
                 (r < 2), (r >= 2 && r < 5));
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        check("restart_count", restart_seen, m_restarts);
        check("flap_count", flap_seen, m_flaps);
        mon_en = 1'b0;

        // Saturation of the BCD counter up to and beyond 9999.
        sat_clear = 1'b1;
        @(negedge Clk);
        sat_clear = 1'b0;
        check("sat_clear", sat_count, 0);
        m = 0;
        extra = 0;
        for (int i = 0; i < 12000 && extra < 8; i++) begin
            a = (m >= 9990) ? 2 - (i % 3) : $urandom_range(0, 2);
            sat_inc1 = (a == 1);
            sat_inc2 = (a == 2);
            @(negedge Clk);
            m = (m + a > 9999) ? 9999 : m + a;
            if (m == 9999) extra++;
            check("sat_count", sat_count, to_bcd(m));
        end
        sat_inc1 = 1'b0;
        sat_inc2 = 1'b0;
        check("sat_final", sat_count, 16'h9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
